// File: rtl/compare_event_tracker.sv
// compare_event_tracker: debounces one-hot comparator flags into a settled relation, counts LESS<->GREATER crossings, emits change events.
// Optional macro CMP_EVT_OVERFLOW_EN adds sticky evt_overflow (set when an event is dropped under backpressure).
// Ports: clk, rst_n (async active-low); in_valid + a_greater/a_equal/a_less sample flags; clear (sync soft reset);
//        state_out (00 UNKNOWN, 01 LESS, 10 EQUAL, 11 GREATER); evt_valid/evt_ready/evt_from/evt_to event handshake;
//        cross_count (saturating crossings); flag_err (one-cycle pulse on a non-one-hot valid sample).
module compare_event_tracker #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a_greater,
    input  logic             a_equal,
    input  logic             a_less,
    input  logic             clear,
    output logic [1:0]       state_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_from,
    output logic [1:0]       evt_to,
    output logic [CNT_W-1:0] cross_count,
    output logic             flag_err
`ifdef CMP_EVT_OVERFLOW_EN
    ,
    output logic             evt_overflow
`endif
);
    localparam logic [7:0] RUN_MAX = 8'(DEBOUNCE);
    logic [1:0] candidate, last_side, code;
    logic [7:0] run, run_nxt;
    logic one_hot, settle, accept, crossing;
    always_comb begin
        one_hot  = $onehot({a_greater, a_equal, a_less});
        code     = a_less ? 2'b01 : a_equal ? 2'b10 : 2'b11;
        run_nxt  = (code == candidate) ? ((run == RUN_MAX) ? run : run + 8'd1) : 8'd1;
        settle   = in_valid && one_hot && run_nxt == RUN_MAX && code != state_out;
        accept   = evt_valid && evt_ready;
        // EQUAL never counts; the first LESS/GREATER after UNKNOWN only primes last_side
        crossing = settle && code != 2'b10 && last_side != 2'b00 && last_side != code;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_out   <= 2'b00;
            evt_valid   <= 1'b0;
            evt_from    <= 2'b00;
            evt_to      <= 2'b00;
            cross_count <= '0;
            flag_err    <= 1'b0;
            candidate   <= 2'b00;
            run         <= 8'd0;
            last_side   <= 2'b00;
`ifdef CMP_EVT_OVERFLOW_EN
            evt_overflow <= 1'b0;
`endif
        end else if (clear) begin
            state_out   <= 2'b00;
            evt_valid   <= 1'b0;
            evt_from    <= 2'b00;
            evt_to      <= 2'b00;
            cross_count <= '0;
            flag_err    <= 1'b0;
            candidate   <= 2'b00;
            run         <= 8'd0;
            last_side   <= 2'b00;
`ifdef CMP_EVT_OVERFLOW_EN
            evt_overflow <= 1'b0;
`endif
        end else begin
            flag_err <= in_valid && !one_hot;
            if (in_valid) begin
                candidate <= one_hot ? code : 2'b00;
                run       <= one_hot ? run_nxt : 8'd0;
            end
            if (settle) state_out <= code;
            if (settle && code != 2'b10) last_side <= code;
            if (crossing && !(&cross_count)) cross_count <= cross_count + 1'b1;
            // a held, unaccepted event wins; a new one loads only into a free or freeing slot
            if (settle && (!evt_valid || accept)) begin
                evt_valid <= 1'b1;
                evt_from  <= state_out;
                evt_to    <= code;
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
`ifdef CMP_EVT_OVERFLOW_EN
            if (settle && evt_valid && !accept) evt_overflow <= 1'b1;
`endif
        end
    end
endmodule

// File: doc/compare_event_tracker.md
Name: compare_event_tracker

Overview:
- Sits directly downstream of the N-bit magnitude comparator and consumes its one-hot greater/equal/less flags once per valid sample.
- Debounces the relation, tracks a settled relation state, counts LESS<->GREATER crossings and emits change events over a valid/ready handshake.
- Typical use: threshold monitoring, where A is a live value and B is a limit register.

Parameters:
- DEBOUNCE, 3, consecutive identical valid samples required to settle a new relation; legal range 1..255.
- CNT_W, 8, width of the saturating crossing counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  comparator flags valid this cycle.
- a_greater  input  1  comparator A>B flag.
- a_equal  input  1  comparator A==B flag.
- a_less  input  1  comparator A<B flag.
- clear  input  1  synchronous soft reset.
- state_out  output  2  settled relation: 00 UNKNOWN, 01 LESS, 10 EQUAL, 11 GREATER.
- evt_valid  output  1  event pending.
- evt_ready  input  1  consumer accepts event.
- evt_from  output  2  settled state before the change.
- evt_to  output  2  settled state after the change.
- cross_count  output  CNT_W  LESS<->GREATER crossings, saturating.
- flag_err  output  1  one-cycle pulse on a non-one-hot valid sample.

Behaviour:
- Clock and reset
  - One clock domain.
  - rst_n is asynchronous active-low: asserting it forces all state immediately; deassertion is synchronous to clk.
- Reset values
  - state_out=00, evt_valid=0, evt_from=00, evt_to=00, cross_count=0, flag_err=0.
  - Internal state: candidate=00, run=0, last_side=00.
- Sample decode
  - Applies only when in_valid=1; cycles with in_valid=0 change nothing.
  - Flags exactly one-hot: code = 01/10/11 for less/equal/greater.
  - Flags not one-hot (zero or multiple set): flag_err=1 next cycle, run=0, candidate=00, state_out unchanged.
- Debounce
  - Code equals candidate: run increments, saturating at DEBOUNCE.
  - Otherwise: candidate=code and run=1.
  - Settling: on the edge where run reaches DEBOUNCE (including run=1 when DEBOUNCE=1) and candidate differs from state_out, state_out takes candidate on that same edge.
  - Latency: the DEBOUNCE-th matching sample is visible on state_out one clock after it is presented.
- Event generation
  - Every settle produces an event: evt_from=old state_out, evt_to=new state.
  - Handshake: evt_valid stays high and evt_from/evt_to stay stable until evt_valid&&evt_ready. The transfer clears evt_valid unless a new event loads on the same edge.
  - New event while an unaccepted event is held: the new event is dropped and the held event is kept. state_out and cross_count still update.
  - New event on the same edge as acceptance: the new event loads and evt_valid stays 1.
- Crossing counter
  - last_side records the most recent settled LESS or GREATER; EQUAL does not update it.
  - A settle into LESS or GREATER whose last_side is the opposite side increments cross_count, saturating at all-ones.
  - The first settle out of UNKNOWN never counts.
  - Example: LESS->EQUAL->GREATER counts 1.
- clear
  - Returns all registers to reset values on the next edge.
  - Takes priority over in_valid and evt_ready in the same cycle.
- Reset mid-handshake: a pending event is discarded and evt_valid drops immediately.

Optional Feature:
- Macro: CMP_EVT_OVERFLOW_EN.
- Defined:
  - Adds output evt_overflow (1 bit, reset 0).
  - Set to 1 when a new event is dropped because an unaccepted event is held.
  - Sticky until clear or rst_n.
- Undefined:
  - Port is absent and drops are silent.
  - All other behaviour is identical.

Test Plan:
- Reset settle: after rst_n, 3 valid LESS samples -> state_out=01 one cycle after the 3rd sample; event from=00 to=01; cross_count=0.
- Glitch rejection: settled LESS, then GREATER,GREATER,LESS,GREATER,GREATER -> no settle until the 3rd consecutive GREATER; in_valid=0 gaps between samples do not break the run.
- Crossing: LESS(x3), EQUAL(x3), GREATER(x3), LESS(x3) -> cross_count=2; events 00->01, 01->10, 10->11, 11->01.
- Backpressure: evt_ready=0 through two settles -> first event held unchanged, second dropped; with CMP_EVT_OVERFLOW_EN, evt_overflow=1. Acceptance on the same edge as a new settle -> evt_valid stays 1 with the new from/to.
- Bad flags: valid sample with greater=1 and less=1 -> flag_err pulse for 1 cycle, run restarts, state_out unchanged. Same check with all flags 0.
- Saturation/clear: CNT_W=2 with 5 crossings -> cross_count=3. Assert clear together with in_valid -> all outputs return to reset values. Pulse rst_n low mid-event -> evt_valid=0 immediately.
